pio_out_pulse: RTL and testbench
================================

PIO_OUT_PULSE -- requirements
Module: pio_out_pulse

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of out_port and of all data registers; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into DATA on reset; bits above DATA_WIDTH are ignored.
REQ-003 Parameter PULSE_LEN_RESET, default 16, value loaded into PULSE_LEN on reset; legal range 0..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data; combinational, zero wait states, zero read latency.
REQ-011 out_port  output  DATA_WIDTH  registered DATA value.

Function
REQ-012 Register map: 0 DATA (R/W), 1 PULSE_MASK (R/W), 2 PULSE_LEN (R/W, 16 bits), 3 STATUS (RO), 4 OUTSET (WO), 5 OUTCLEAR (WO); addresses 6 and 7 read 0 and ignore writes.
REQ-013 readdata shall be zero-extended above the register width; OUTSET and OUTCLEAR shall read 0.
REQ-014 STATUS bit0 shall be BUSY (pulse counter nonzero); bits 31:1 read 0.
REQ-015 DATA write: DATA <= writedata[DATA_WIDTH-1:0] at the end of the write cycle.
REQ-016 OUTSET write: DATA <= DATA | wd, where wd = writedata[DATA_WIDTH-1:0].
REQ-017 OUTCLEAR write: DATA <= DATA & ~wd, where wd = writedata[DATA_WIDTH-1:0].
REQ-018 out_port shall equal DATA at all times; it changes in the cycle after the write.
REQ-019 Pulse start: a DATA or OUTSET write in cycle T with PULSE_LEN=L≠0 that leaves any bit 1 in (new DATA & PULSE_MASK) shall load the 16-bit counter CNT with L at the end of T.
REQ-020 Countdown: while CNT≠0 and no pulse start occurs, CNT decrements by 1 each cycle.
REQ-021 Expiry: in a cycle with CNT=1 and no register write, DATA <= DATA & ~PULSE_MASK and CNT <= 0; masked bits are therefore high for exactly L cycles (T+1..T+L).
REQ-022 A pulse start during a running pulse (including in the expiry cycle) shall reload CNT with PULSE_LEN; the write result wins and no clear is applied in that cycle (retrigger).
REQ-023 OUTCLEAR or PULSE_MASK writes during a running pulse shall not alter CNT; at expiry the current PULSE_MASK is applied.
REQ-024 A PULSE_LEN write shall not alter a running CNT; the new value applies from the next pulse start.
REQ-025 If PULSE_LEN=0, no pulse starts: masked bits behave as plain level outputs.
REQ-026 Unmasked bits shall never be modified by expiry.
REQ-027 Writes with chipselect=0 or write_n=1 shall have no effect; reads have no side effects.

Reset
REQ-028 When reset=1 at a clock edge: DATA <= RESET_VALUE, PULSE_MASK <= 0, PULSE_LEN <= PULSE_LEN_RESET, CNT <= 0.
REQ-029 Reset overrides any simultaneous write, and a reset mid-pulse aborts the pulse with out_port = RESET_VALUE in the next cycle.
REQ-030 out_port shall be RESET_VALUE, and readdata at every address shall reflect the reset register values, from the first cycle after reset.

Verification (DATA_WIDTH=8, RESET_VALUE=8'hA5, PULSE_LEN_RESET=16)
REQ-031 Reset, then read address 0..7 -> 0xA5, 0, 16, 0, 0, 0, 0, 0; out_port=0xA5.
REQ-032 Write DATA=0x0F; OUTSET 0x30; OUTCLEAR 0x05 -> out_port 0x0F, then 0x3F, then 0x3A, each one cycle after its write.
REQ-033 Write PULSE_MASK=0x01, PULSE_LEN=4, then OUTSET 0x01 at cycle T -> bit0 high in cycles T+1..T+4 and low at T+5; BUSY=1 in cycles T+1..T+4.
REQ-034 Run REQ-033 and repeat the OUTSET at T+4 -> bit0 stays high until T+8, with no low glitch.
REQ-035 Start a pulse, write PULSE_MASK=0 mid-pulse -> bit0 remains high after CNT reaches 0; with PULSE_LEN=0 and OUTSET 0x01 -> bit0 stays high and BUSY=0.
REQ-036 Start a pulse, assert reset at T+2 -> out_port=0xA5 from T+3, BUSY=0.

Source files
------------

// File: rtl/pio_out_pulse.sv
// Avalon-MM parallel output port with self-clearing pulse bits.
// Bits selected by PULSE_MASK drop back to 0 a programmable number of cycles after being set.
module pio_out_pulse #(
    parameter int          DATA_WIDTH      = 8,
    parameter logic [31:0] RESET_VALUE     = 32'h0,
    parameter int          PULSE_LEN_RESET = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];
    localparam logic [15:0]           LEN_RST  = 16'(PULSE_LEN_RESET);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] wr_result;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [15:0]           len_q;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_nxt;
    logic                  wr_en;
    logic                  pulse_start;
    logic                  unused_wd;

    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign wr_en     = chipselect & ~write_n;

    always_comb begin
        wr_result = data_q;
        if (wr_en) begin
            case (address)
                3'd0:    wr_result = wd;
                3'd4:    wr_result = data_q | wd;
                3'd5:    wr_result = data_q & ~wd;
                default: wr_result = data_q;
            endcase
        end
    end

    assign pulse_start = wr_en && (address == 3'd0 || address == 3'd4) &&
                         (len_q != 16'd0) && (|(wr_result & mask_q));

    // A retrigger takes precedence over expiry; expiry clears masked bits of the write result.
    always_comb begin
        data_nxt = wr_result;
        cnt_nxt  = cnt_q;
        if (pulse_start) begin
            cnt_nxt = len_q;
        end else if (cnt_q != 16'd0) begin
            cnt_nxt = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                data_nxt = wr_result & ~mask_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= DATA_RST;
            mask_q <= '0;
            len_q  <= LEN_RST;
            cnt_q  <= '0;
        end else begin
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            if (wr_en && address == 3'd1) begin
                mask_q <= wd;
            end
            if (wr_en && address == 3'd2) begin
                len_q <= writedata[15:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[DATA_WIDTH-1:0] = data_q;
            3'd1:    readdata[DATA_WIDTH-1:0] = mask_q;
            3'd2:    readdata[15:0]           = len_q;
            3'd3:    readdata[0]              = (cnt_q != 16'd0);
            default: readdata = '0;
        endcase
    end

    assign out_port = data_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Bench for pio_out_pulse: directed register/pulse scenarios plus random traffic
// against a model that tracks each pulse by its absolute end cycle.
module tb_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [7:0]  m_data;
    bit [7:0]  m_mask;
    bit [15:0] m_len;
    bit        m_active;
    int        m_end;
    int        m_cyc;

    pio_out_pulse #(
        .DATA_WIDTH(8),
        .RESET_VALUE(32'hA5),
        .PULSE_LEN_RESET(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input bit [2:0] a);
        case (a)
            3'd0:    return {24'b0, m_data};
            3'd1:    return {24'b0, m_mask};
            3'd2:    return {16'b0, m_len};
            3'd3:    return {31'b0, m_active};
            default: return 32'b0;
        endcase
    endfunction

    task automatic rd(input bit [2:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    // One clock: apply inputs, advance the model, then check out_port and a random read.
    task automatic op(input bit rst, input bit cs, input bit wn, input bit [2:0] a, input bit [31:0] d);
        bit [7:0]  nd;
        bit [7:0]  nmask;
        bit [15:0] nlen;
        bit        wr;
        bit        start;
        bit [2:0]  ra;
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
        wr    = cs && !wn;
        nd    = m_data;
        nmask = m_mask;
        nlen  = m_len;
        if (wr) begin
            case (a)
                3'd0: nd = d[7:0];
                3'd1: nmask = d[7:0];
                3'd2: nlen = d[15:0];
                3'd4: nd = m_data | d[7:0];
                3'd5: nd = m_data & ~d[7:0];
                default: ;
            endcase
        end
        start = wr && (a == 3'd0 || a == 3'd4) && m_len != 0 && (nd & m_mask) != 0;
        if (start) begin
            m_active = 1'b1;
            m_end    = m_cyc + int'(m_len);
        end else if (m_active && m_cyc == m_end) begin
            nd       = nd & ~m_mask;
            m_active = 1'b0;
        end
        if (rst) begin
            nd = 8'hA5; nmask = 8'h00; nlen = 16'd16; m_active = 1'b0;
        end
        @(posedge clk);
        #1;
        m_data = nd; m_mask = nmask; m_len = nlen;
        m_cyc++;
        chk("out_port", {24'b0, out_port}, {24'b0, m_data});
        ra = 3'($urandom_range(0, 7));
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = ra;
        #1;
        chk($sformatf("rd@%0d", ra), readdata, m_read(ra));
    endtask

    task automatic wr(input bit [2:0] a, input bit [31:0] d);
        op(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF);
    endtask

    task automatic chk_bit0_busy(input string tag, input bit b0, input bit busy);
        logic [31:0] v;
        chk({tag, "_bit0"}, {31'b0, out_port[0]}, {31'b0, b0});
        rd(3'd3, v);
        chk({tag, "_busy"}, v, {31'b0, busy});
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp_rd [8];
        exp_rd = '{32'hA5, 0, 16, 0, 0, 0, 0, 0};
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
        m_cyc = 0; m_end = 0; m_active = 1'b0;
        m_data = 8'h00; m_mask = 8'h00; m_len = 16'd0;
        #2;

        // Reset overriding a simultaneous DATA write
        op(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0055);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("reset_rd@%0d", i), v, exp_rd[i]);
        end
        chk("reset_out", {24'b0, out_port}, 32'hA5);

        // Plain level writes
        wr(3'd0, 32'h0F);  chk("data_wr",  {24'b0, out_port}, 32'h0F);
        wr(3'd4, 32'h30);  chk("outset",   {24'b0, out_port}, 32'h3F);
        wr(3'd5, 32'h05);  chk("outclear", {24'b0, out_port}, 32'h3A);

        // Single pulse of 4 cycles
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h04);
        wr(3'd4, 32'h01);
        for (int i = 1; i <= 4; i++) begin
            chk_bit0_busy($sformatf("pulse_t%0d", i), 1'b1, 1'b1);
            if (i < 4) idle();
        end
        idle();
        chk_bit0_busy("pulse_t5", 1'b0, 1'b0);

        // Retrigger in the expiry cycle
        wr(3'd4, 32'h01);
        idle(); idle(); idle();
        wr(3'd4, 32'h01);
        for (int i = 5; i <= 8; i++) begin
            chk_bit0_busy($sformatf("retrig_t%0d", i), 1'b1, 1'b1);
            if (i < 8) idle();
        end
        idle();
        chk_bit0_busy("retrig_t9", 1'b0, 1'b0);

        // Mask removed mid-pulse leaves the bit set
        wr(3'd4, 32'h01);
        idle();
        wr(3'd1, 32'h00);
        idle(); idle(); idle();
        chk_bit0_busy("mask_off", 1'b1, 1'b0);

        // Zero length: masked bit acts as a level
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h01);
        wr(3'd5, 32'h01);
        wr(3'd4, 32'h01);
        idle(); idle(); idle();
        chk_bit0_busy("len0", 1'b1, 1'b0);

        // Reset mid-pulse
        wr(3'd2, 32'h04);
        wr(3'd5, 32'h01);
        wr(3'd4, 32'h01);
        idle();
        op(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("rst_mid_out", {24'b0, out_port}, 32'hA5);
        rd(3'd3, v);
        chk("rst_mid_busy", v, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit        rst;
            bit        cs;
            bit        wn;
            bit [2:0]  a;
            bit [31:0] d;
            rst = ($urandom_range(0, 149) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 2) != 0);
            a   = 3'($urandom_range(0, 7));
            d   = $urandom;
            if (a == 3'd2) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            op(rst, cs, wn, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
